// File: rtl/dma_channel_memory_map_if.sv
// mmio_if: 16-bit word-addressed MMIO bus with 64-bit data.
//   wr_en/wr_addr/wr_data : single-cycle write strobe, address and data
//   rd_en/rd_addr         : read request; rd_data returns one cycle later
//   rd_data               : read response, held while no read is requested
// The register file takes the "user" side; a bus master or bench takes "host".
interface mmio_if;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [63:0] wr_data;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [63:0] rd_data;

    modport user (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data
    );

    modport host (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data
    );
endinterface

// File: rtl/dma_channel_memory_map.sv
// dma_channel_memory_map: MMIO register file for a multi-channel DMA AFU.
// Each channel owns a block of 64-bit registers at BASE_ADDR + c*CH_STRIDE:
//   +0 GO (W), +2 RD_ADDR (RW), +4 WR_ADDR (RW), +6 SIZE (RW),
//   +8 STATUS (R: bit0 done, bit1 busy; W: bit0 clears done), +A CYCLES (R).
// Global read-only registers: 0x40 channel count, 0x42 done bitmask.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   mmio       : MMIO bus (user side)
//   rd_addr    : per-channel read start address to the engines
//   wr_addr    : per-channel write start address to the engines
//   size       : per-channel transfer size in cache lines
//   go         : one-cycle start pulse per channel
//   done       : completion from each engine (level or pulse)
//   busy_any   : registered OR of all channel BUSY states
module dma_channel_memory_map #(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned ADDR_WIDTH   = 64,
    parameter int unsigned SIZE_WIDTH   = 32,
    parameter int unsigned COUNT_WIDTH  = 48,
    parameter logic [15:0] BASE_ADDR    = 16'h0050,
    parameter logic [15:0] CH_STRIDE    = 16'h0010
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    mmio_if.user                                      mmio,
    output logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]   rd_addr,
    output logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]   wr_addr,
    output logic [NUM_CHANNELS-1:0][SIZE_WIDTH-1:0]   size,
    output logic [NUM_CHANNELS-1:0]                   go,
    input  logic [NUM_CHANNELS-1:0]                   done,
    output logic                                      busy_any
);

    localparam logic [15:0] NumChAddr    = 16'h0040;
    localparam logic [15:0] DoneMaskAddr = 16'h0042;
    localparam logic [15:0] OffGo        = 16'h0000;
    localparam logic [15:0] OffRdAddr    = 16'h0002;
    localparam logic [15:0] OffWrAddr    = 16'h0004;
    localparam logic [15:0] OffSize      = 16'h0006;
    localparam logic [15:0] OffStatus    = 16'h0008;
    localparam logic [15:0] OffCycles    = 16'h000A;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } ch_state_e;

    ch_state_e                                state_q [NUM_CHANNELS];
    ch_state_e                                state_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [NUM_CHANNELS-1:0][SIZE_WIDTH-1:0]  size_q, size_d;
    logic [NUM_CHANNELS-1:0][COUNT_WIDTH-1:0] cycles_q, cycles_d;
    logic [NUM_CHANNELS-1:0]                  go_q, go_d;
    logic                                     busy_any_q, busy_any_d;
    logic [63:0]                              rd_data_q, rd_data_d;

    logic [NUM_CHANNELS-1:0] done_vec;   // current DONE states
    logic [NUM_CHANNELS-1:0] busy_vec;   // current BUSY states
    logic [NUM_CHANNELS-1:0] busy_nxt;   // BUSY states after this edge

    function automatic logic [15:0] ch_base(input int unsigned c);
        return 16'(BASE_ADDR + 16'(c) * CH_STRIDE);
    endfunction

    always_comb begin
        done_vec = '0;
        busy_vec = '0;
        busy_nxt = '0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            done_vec[c] = (state_q[c] == StDone);
            busy_vec[c] = (state_q[c] == StBusy);
            busy_nxt[c] = (state_d[c] == StBusy);
        end
    end

    // Channel FSMs and configuration registers.
    always_comb begin
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        size_d    = size_q;
        cycles_d  = cycles_q;
        go_d      = '0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            state_d[c] = state_q[c];
            if (state_q[c] == StBusy) begin
                // All writes are dropped while busy so the engine sees stable config.
                cycles_d[c] = (&cycles_q[c]) ? cycles_q[c] : cycles_q[c] + COUNT_WIDTH'(1);
                // go_q high means this is the first BUSY cycle; a done here is stale.
                if (done[c] && !go_q[c]) begin
                    state_d[c] = StDone;
                end
            end else if (mmio.wr_en) begin
                if (mmio.wr_addr == ch_base(c) + OffGo) begin
                    if (mmio.wr_data[0]) begin
                        state_d[c]  = StBusy;
                        go_d[c]     = 1'b1;
                        cycles_d[c] = '0;
                    end
                end else if (mmio.wr_addr == ch_base(c) + OffStatus) begin
                    if (mmio.wr_data[0] && state_q[c] == StDone) begin
                        state_d[c] = StIdle;
                    end
                end else if (mmio.wr_addr == ch_base(c) + OffRdAddr) begin
                    rd_addr_d[c] = mmio.wr_data[ADDR_WIDTH-1:0];
                end else if (mmio.wr_addr == ch_base(c) + OffWrAddr) begin
                    wr_addr_d[c] = mmio.wr_data[ADDR_WIDTH-1:0];
                end else if (mmio.wr_addr == ch_base(c) + OffSize) begin
                    size_d[c] = mmio.wr_data[SIZE_WIDTH-1:0];
                end
            end
        end
        busy_any_d = |busy_nxt;
    end

    // Read mux works from registered state, so a same-cycle write is not visible yet.
    always_comb begin
        rd_data_d = rd_data_q;
        if (mmio.rd_en) begin
            rd_data_d = '0;
            if (mmio.rd_addr == NumChAddr) begin
                rd_data_d = 64'(8'(NUM_CHANNELS));
            end
            if (mmio.rd_addr == DoneMaskAddr) begin
                rd_data_d = 64'(done_vec);
            end
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                if (mmio.rd_addr == ch_base(c) + OffRdAddr) begin
                    rd_data_d = 64'(rd_addr_q[c]);
                end
                if (mmio.rd_addr == ch_base(c) + OffWrAddr) begin
                    rd_data_d = 64'(wr_addr_q[c]);
                end
                if (mmio.rd_addr == ch_base(c) + OffSize) begin
                    rd_data_d = 64'(size_q[c]);
                end
                if (mmio.rd_addr == ch_base(c) + OffStatus) begin
                    rd_data_d = {62'b0, busy_vec[c], done_vec[c]};
                end
                if (mmio.rd_addr == ch_base(c) + OffCycles) begin
                    rd_data_d = 64'(cycles_q[c]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c] <= StIdle;
            end
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            size_q     <= '0;
            cycles_q   <= '0;
            go_q       <= '0;
            busy_any_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c] <= state_d[c];
            end
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            size_q     <= size_d;
            cycles_q   <= cycles_d;
            go_q       <= go_d;
            busy_any_q <= busy_any_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_addr      = rd_addr_q;
    assign wr_addr      = wr_addr_q;
    assign size         = size_q;
    assign go           = go_q;
    assign busy_any     = busy_any_q;
    assign mmio.rd_data = rd_data_q;

endmodule

// File: tb/tb_dma_channel_memory_map.sv
// Bench for dma_channel_memory_map: a default instance (4 channels, 48-bit counters) and a
// small instance (1 channel, 4-bit counters) share clock and reset. A reference model updates
// on each clock edge; reads push their expected value into a queue that a monitor pops when
// rd_data becomes valid. The monitor also compares go, busy_any and config outputs every cycle.
module tb_dma_channel_memory_map;

    localparam int NC0 = 4;
    localparam int NC1 = 1;
    localparam int MIdle = 0;
    localparam int MBusy = 1;
    localparam int MDone = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mmio_if m0 ();
    mmio_if m1 ();

    logic [NC0-1:0][63:0] rd_addr0, wr_addr0;
    logic [NC0-1:0][31:0] size0;
    logic [NC0-1:0]       go0, done0;
    logic                 busy0;
    logic [NC1-1:0][63:0] rd_addr1, wr_addr1;
    logic [NC1-1:0][31:0] size1;
    logic [NC1-1:0]       go1, done1;
    logic                 busy1;

    dma_channel_memory_map #(.NUM_CHANNELS(NC0)) dut0 (
        .clk(clk), .rst_n(rst_n), .mmio(m0),
        .rd_addr(rd_addr0), .wr_addr(wr_addr0), .size(size0),
        .go(go0), .done(done0), .busy_any(busy0)
    );

    dma_channel_memory_map #(.NUM_CHANNELS(NC1), .COUNT_WIDTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .mmio(m1),
        .rd_addr(rd_addr1), .wr_addr(wr_addr1), .size(size1),
        .go(go1), .done(done1), .busy_any(busy1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] val;
        logic [15:0] addr;
    } rd_exp_t;

    rd_exp_t q0[$];
    rd_exp_t q1[$];

    int                nch [2] = '{NC0, NC1};
    longint unsigned   cmax[2] = '{64'h0000_FFFF_FFFF_FFFF, 64'd15};
    int                st  [2][8];
    longint unsigned   cyc [2][8];
    logic [63:0]       ra  [2][8];
    logic [63:0]       wa  [2][8];
    logic [31:0]       sz  [2][8];
    logic [7:0]        goe [2];
    logic              bexp[2];

    logic        s_we, s_re;
    logic [15:0] s_wa, s_ra;
    logic [63:0] s_wd;
    logic [7:0]  s_dn, ng;

    function automatic logic [15:0] base_of(input int c);
        return 16'(16'h0050 + c * 16'h0010);
    endfunction

    function automatic logic [63:0] exp_read(input int d, input logic [15:0] a);
        logic [63:0] m;
        if (a == 16'h0040) return 64'(nch[d]);
        if (a == 16'h0042) begin
            m = '0;
            for (int c = 0; c < nch[d]; c++) m[c] = (st[d][c] == MDone);
            return m;
        end
        for (int c = 0; c < nch[d]; c++) begin
            if (a == base_of(c) + 16'h2) return ra[d][c];
            if (a == base_of(c) + 16'h4) return wa[d][c];
            if (a == base_of(c) + 16'h6) return 64'(sz[d][c]);
            if (a == base_of(c) + 16'h8) return {62'b0, st[d][c] == MBusy, st[d][c] == MDone};
            if (a == base_of(c) + 16'hA) return cyc[d][c];
        end
        return 64'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 8; c++) begin
                    st[d][c] = MIdle; cyc[d][c] = 0; ra[d][c] = '0; wa[d][c] = '0; sz[d][c] = '0;
                end
                goe[d] = '0;
                bexp[d] = 1'b0;
            end
            q0.delete();
            q1.delete();
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (d == 0) begin
                    s_we = m0.wr_en; s_wa = m0.wr_addr; s_wd = m0.wr_data;
                    s_re = m0.rd_en; s_ra = m0.rd_addr; s_dn = 8'(done0);
                end else begin
                    s_we = m1.wr_en; s_wa = m1.wr_addr; s_wd = m1.wr_data;
                    s_re = m1.rd_en; s_ra = m1.rd_addr; s_dn = 8'(done1);
                end
                if (s_re) begin
                    if (d == 0) q0.push_back('{exp_read(d, s_ra), s_ra});
                    else        q1.push_back('{exp_read(d, s_ra), s_ra});
                end
                ng = '0;
                for (int c = 0; c < nch[d]; c++) begin
                    if (st[d][c] == MBusy) begin
                        if (cyc[d][c] < cmax[d]) cyc[d][c]++;
                        // A done that coincides with the start pulse is ignored.
                        if (s_dn[c] && !goe[d][c]) st[d][c] = MDone;
                    end else if (s_we) begin
                        if (s_wa == base_of(c) && s_wd[0]) begin
                            st[d][c] = MBusy; ng[c] = 1'b1; cyc[d][c] = 0;
                        end else if (s_wa == base_of(c) + 16'h8 && s_wd[0] && st[d][c] == MDone) begin
                            st[d][c] = MIdle;
                        end else if (s_wa == base_of(c) + 16'h2) begin
                            ra[d][c] = s_wd;
                        end else if (s_wa == base_of(c) + 16'h4) begin
                            wa[d][c] = s_wd;
                        end else if (s_wa == base_of(c) + 16'h6) begin
                            sz[d][c] = s_wd[31:0];
                        end
                    end
                end
                goe[d] = ng;
                bexp[d] = 1'b0;
                for (int c = 0; c < nch[d]; c++) if (st[d][c] == MBusy) bexp[d] = 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    logic pend0, pend1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend0 <= 1'b0;
            pend1 <= 1'b0;
        end else begin
            pend0 <= m0.rd_en;
            pend1 <= m1.rd_en;
        end
    end

    always @(negedge clk) begin
        rd_exp_t e;
        if (rst_n) begin
            if (pend0) begin
                if (q0.size() == 0) check("rd0_queue_empty", 64'd0, 64'd1);
                else begin
                    e = q0.pop_front();
                    check($sformatf("rd0[%h]", e.addr), m0.rd_data, e.val);
                end
            end
            if (pend1) begin
                if (q1.size() == 0) check("rd1_queue_empty", 64'd0, 64'd1);
                else begin
                    e = q1.pop_front();
                    check($sformatf("rd1[%h]", e.addr), m1.rd_data, e.val);
                end
            end
            check("go0", 64'(go0), 64'(goe[0][NC0-1:0]));
            check("go1", 64'(go1), 64'(goe[1][NC1-1:0]));
            check("busy_any0", 64'(busy0), 64'(bexp[0]));
            check("busy_any1", 64'(busy1), 64'(bexp[1]));
            for (int c = 0; c < NC0; c++) begin
                check($sformatf("rd_addr0[%0d]", c), rd_addr0[c], ra[0][c]);
                check($sformatf("wr_addr0[%0d]", c), wr_addr0[c], wa[0][c]);
                check($sformatf("size0[%0d]", c), 64'(size0[c]), 64'(sz[0][c]));
            end
            check("size1", 64'(size1[0]), 64'(sz[1][0]));
            check("rd_addr1", rd_addr1[0], ra[1][0]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int d, input logic we, input logic [15:0] wa_i,
                         input logic [63:0] wd, input logic re, input logic [15:0] ra_i);
        if (d == 0) begin
            m0.wr_en = we; m0.wr_addr = wa_i; m0.wr_data = wd; m0.rd_en = re; m0.rd_addr = ra_i;
        end else begin
            m1.wr_en = we; m1.wr_addr = wa_i; m1.wr_data = wd; m1.rd_en = re; m1.rd_addr = ra_i;
        end
    endtask

    task automatic idle_all();
        drive(0, 1'b0, '0, '0, 1'b0, '0);
        drive(1, 1'b0, '0, '0, 1'b0, '0);
        done0 = '0;
        done1 = '0;
    endtask

    task automatic wr(input int d, input logic [15:0] a, input logic [63:0] v);
        @(negedge clk);
        drive(d, 1'b1, a, v, 1'b0, '0);
        @(posedge clk);
        #1 idle_all();
    endtask

    task automatic rd(input int d, input logic [15:0] a);
        @(negedge clk);
        drive(d, 1'b0, '0, '0, 1'b1, a);
        @(posedge clk);
        #1 idle_all();
    endtask

    task automatic rw(input int d, input logic [15:0] a, input logic [63:0] v);
        @(negedge clk);
        drive(d, 1'b1, a, v, 1'b1, a);
        @(posedge clk);
        #1 idle_all();
    endtask

    task automatic pulse_done(input int d, input int c);
        @(negedge clk);
        if (d == 0) done0[c] = 1'b1;
        else        done1[c] = 1'b1;
        @(posedge clk);
        #1 idle_all();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pick_addr(input int d);
        int r;
        logic [15:0] a;
        r = $urandom_range(0, 11);
        if (r == 0) return 16'h0040;
        if (r == 1) return 16'h0042;
        if (r == 2) return 16'($urandom);
        a = base_of($urandom_range(0, nch[d] - 1)) + 16'(2 * $urandom_range(0, 5));
        if ($urandom_range(0, 9) == 0) a = a + 16'd1;
        return a;
    endfunction

    task automatic check_reset_outputs();
        check("rst_go0", 64'(go0), 64'd0);
        check("rst_busy0", 64'(busy0), 64'd0);
        check("rst_rd_addr0_1", rd_addr0[1], 64'd0);
        check("rst_size0_1", 64'(size0[1]), 64'd0);
        check("rst_rd_data0", m0.rd_data, 64'd0);
        check("rst_rd_data1", m1.rd_data, 64'd0);
        check("rst_busy1", 64'(busy1), 64'd0);
    endtask

    initial begin
        idle_all();
        // 1: reset values, then every mapped address of the default instance
        wait_cycles(3);
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        rd(0, 16'h0040);
        rd(0, 16'h0042);
        for (int c = 0; c < NC0; c++) begin
            for (int o = 0; o < 12; o += 2) rd(0, base_of(c) + 16'(o));
        end
        rd(1, 16'h0040);

        // 2: configure and start channel 1
        wr(0, 16'h0062, 64'h1000);
        wr(0, 16'h0064, 64'h2000);
        wr(0, 16'h0066, 64'h8);
        wr(0, 16'h0060, 64'h0);   // bit0 clear: no start
        wr(0, 16'h0060, 64'h1);
        rd(0, 16'h0068);

        // 3: config lock while busy
        wr(0, 16'h0066, 64'd99);
        wr(0, 16'h0060, 64'h1);
        wr(0, 16'h0068, 64'h1);
        rd(0, 16'h0066);

        // 4: completion after roughly 20 busy cycles, then software clear
        wait_cycles(11);
        pulse_done(0, 1);
        rd(0, 16'h0068);
        rd(0, 16'h006A);
        rd(0, 16'h0042);
        rw(0, 16'h0068, 64'h1);   // read sees DONE, write clears it
        rd(0, 16'h0068);

        // 5: two channels back-to-back, channel 3 finishes first
        wr(0, 16'h0050, 64'h1);
        wr(0, 16'h0080, 64'h1);
        wait_cycles(4);
        pulse_done(0, 3);
        rd(0, 16'h0042);
        wait_cycles(3);
        pulse_done(0, 0);
        rd(0, 16'h0042);
        wait_cycles(2);

        // done coinciding with the go pulse is ignored
        wr(0, 16'h0070, 64'h1);
        pulse_done(0, 2);
        rd(0, 16'h0078);
        pulse_done(0, 2);
        rd(0, 16'h0078);
        wr(0, 16'h0070, 64'h1);   // restart from DONE

        // 6: saturation on the 4-bit counter instance
        wr(1, 16'h0050, 64'h1);
        wait_cycles(20);
        rd(1, 16'h005A);
        pulse_done(1, 0);
        rd(1, 16'h005A);
        rd(1, 16'h0058);

        // abort: reset while channel 2 of the default instance is busy
        wait_cycles(2);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        rd(0, 16'h0078);
        rd(0, 16'h007A);

        // randomized traffic on both instances
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                drive(d, $urandom_range(0, 2) == 0, pick_addr(d), {$urandom, $urandom},
                      $urandom_range(0, 1) == 1, pick_addr(d));
            end
            for (int c = 0; c < NC0; c++) done0[c] = ($urandom_range(0, 9) == 0);
            done1[0] = ($urandom_range(0, 14) == 0);
        end
        @(negedge clk);
        idle_all();
        wait_cycles(3);
        check("rd0_queue_drained", 64'(q0.size()), 64'd0);
        check("rd1_queue_drained", 64'(q1.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
